// File: rtl/test_ram_waitstate.sv
// Synchronous word RAM behind a req/ready handshake with programmable wait
// states. It models slow 65c816 bus memory for CPU test benches and can flag
// addresses that fall outside the implemented depth.
module test_ram_waitstate #(
   parameter int unsigned            DATA_WIDTH  = 8,
   parameter int unsigned            ADDR_WIDTH  = 24,
   parameter int unsigned            DEPTH_LOG2  = 16,
   parameter int unsigned            WAIT_STATES = 2,
   parameter bit                     MIRROR      = 1'b1,
   parameter logic [DATA_WIDTH-1:0]  FAULT_DATA  = 'hFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  ready,
   output logic                  fault,
   output logic                  busy
);

   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [7:0]  WAIT_INIT = (WAIT_STATES == 0) ? 8'd0 : 8'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [7:0]              cnt;
   logic [7:0]              cnt_next;
   logic                    accept;
   logic                    access_now;

   logic                    lat_we;
   logic [DEPTH_LOG2-1:0]   lat_idx;
   logic [DATA_WIDTH-1:0]   lat_data;
   logic                    lat_oor;

   logic                    addr_high;
   logic                    addr_oor;
   logic                    mem_wr;

   logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

   // Out-of-range is decided from the raw address when the request is
   // accepted, so only the index bits need to be held for the access.
   assign addr_high = |(addr >> DEPTH_LOG2);
   assign addr_oor  = !MIRROR && addr_high;

   assign busy   = (state != ST_IDLE);
   assign mem_wr = access_now && lat_we && !lat_oor;

   // State register and wait-state counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: idle, count down wait states, then one access cycle.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      access_now = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_next = ST_ACCESS;
               end else begin
                  cnt_next   = WAIT_INIT;
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 8'd0) begin
               state_next = ST_ACCESS;
            end else begin
               cnt_next = cnt - 8'd1;
            end
         end
         ST_ACCESS: begin
            access_now = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Capture the request at acceptance; later changes on the inputs are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_we   <= 1'b0;
         lat_idx  <= '0;
         lat_data <= '0;
         lat_oor  <= 1'b0;
      end else if (accept) begin
         lat_we   <= we;
         lat_idx  <= addr[DEPTH_LOG2-1:0];
         lat_data <= data_in;
         lat_oor  <= addr_oor;
      end
   end

   // Completion pulse, fault flag and read data; data_out only moves on reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready    <= 1'b0;
         fault    <= 1'b0;
         data_out <= '0;
      end else begin
         ready <= access_now;
         fault <= access_now && lat_oor;
         if (access_now && !lat_we) begin
            data_out <= lat_oor ? FAULT_DATA : mem[lat_idx];
         end
      end
   end

   // Memory array; contents survive reset, and an aborted access never
   // reaches ACCESS so its write is dropped.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[lat_idx] <= lat_data;
      end
   end

endmodule

// File: tb/tb_test_ram_waitstate.sv
// Directed bench for test_ram_waitstate with three instances:
// u0 WAIT_STATES=2 MIRROR=0, u1 WAIT_STATES=0 MIRROR=1, u2 WAIT_STATES=3 MIRROR=1.
module tb_test_ram_waitstate;

   logic             clk = 1'b0;
   logic [2:0]       rst_v = '0;
   logic [2:0]       req_v = '0;
   logic [2:0]       we_v = '0;
   logic [2:0][23:0] addr_v = '0;
   logic [2:0][7:0]  din_v = '0;
   logic [2:0][7:0]  dout_v;
   logic [2:0]       ready_v;
   logic [2:0]       fault_v;
   logic [2:0]       busy_v;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   test_ram_waitstate #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .DEPTH_LOG2(16),
                        .WAIT_STATES(2), .MIRROR(1'b0), .FAULT_DATA(8'hFF)) u0 (
      .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
      .data_in(din_v[0]), .data_out(dout_v[0]), .ready(ready_v[0]),
      .fault(fault_v[0]), .busy(busy_v[0]));

   test_ram_waitstate #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .DEPTH_LOG2(16),
                        .WAIT_STATES(0), .MIRROR(1'b1), .FAULT_DATA(8'hFF)) u1 (
      .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
      .data_in(din_v[1]), .data_out(dout_v[1]), .ready(ready_v[1]),
      .fault(fault_v[1]), .busy(busy_v[1]));

   test_ram_waitstate #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .DEPTH_LOG2(16),
                        .WAIT_STATES(3), .MIRROR(1'b1), .FAULT_DATA(8'hFF)) u2 (
      .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
      .data_in(din_v[2]), .data_out(dout_v[2]), .ready(ready_v[2]),
      .fault(fault_v[2]), .busy(busy_v[2]));

   // Issue one access on instance i and observe it: lat counts edges from the
   // accepting edge to the first sample with ready=1 (bounded at 40).
   task automatic do_access(input int unsigned i, input logic w, input logic [23:0] ad,
                            input logic [7:0] d, output int lat, output logic [7:0] dout,
                            output logic flt, output logic busy_acc, output logic busy_rdy,
                            output logic rdy_after);
      @(negedge clk);
      req_v[i] = 1'b1; we_v[i] = w; addr_v[i] = ad; din_v[i] = d;
      @(posedge clk); #1;
      req_v[i] = 1'b0;
      busy_acc = busy_v[i];
      lat = 0;
      while (ready_v[i] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      dout = dout_v[i]; flt = fault_v[i]; busy_rdy = busy_v[i];
      @(posedge clk); #1;
      rdy_after = ready_v[i] | fault_v[i];
   endtask

   task automatic test_reset();
      #2;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({dout_v[i], ready_v[i], fault_v[i], busy_v[i]} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_outputs u%0d: got dout=%h rdy=%b flt=%b busy=%b, want all 0",
                     i, dout_v[i], ready_v[i], fault_v[i], busy_v[i]);
         end
      end
      @(negedge clk);
      rst_v = 3'b111;
   endtask

   // T1: write then read on u0 (2 wait states).
   task automatic test_write_read();
      int lat; logic [7:0] dout; logic flt, ba, br, ra;
      do_access(0, 1'b1, 24'h000010, 8'h5A, lat, dout, flt, ba, br, ra);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
      n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL wr_keeps_dout: got %h want 00", dout); end
      n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL wr_fault: got %b want 0", flt); end
      n_cmp++; if (ba !== 1'b1) begin n_bad++; $display("FAIL wr_busy_after_accept: got %b want 1", ba); end
      n_cmp++; if (br !== 1'b0) begin n_bad++; $display("FAIL wr_busy_in_ready: got %b want 0", br); end
      n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL wr_ready_one_cycle: got %b want 0", ra); end
      do_access(0, 1'b0, 24'h000010, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
      n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL rd_data: got %h want 5a", dout); end
      n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL rd_fault: got %b want 0", flt); end
      n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL rd_ready_one_cycle: got %b want 0", ra); end
   endtask

   // T3: out-of-range accesses on u0 (MIRROR=0).
   task automatic test_range_fault();
      int lat; logic [7:0] dout; logic flt, ba, br, ra;
      do_access(0, 1'b1, 24'h000004, 8'h99, lat, dout, flt, ba, br, ra);
      n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL inrange_wr_fault: got %b want 0", flt); end
      do_access(0, 1'b1, 24'h010004, 8'h11, lat, dout, flt, ba, br, ra);
      n_cmp++; if (flt !== 1'b1) begin n_bad++; $display("FAIL oor_wr_fault: got %b want 1", flt); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL oor_wr_latency: got %0d want 3", lat); end
      n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL oor_fault_one_cycle: got %b want 0", ra); end
      do_access(0, 1'b0, 24'h000004, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (dout !== 8'h99) begin n_bad++; $display("FAIL oor_wr_suppressed: got %h want 99", dout); end
      n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL inrange_rd_fault: got %b want 0", flt); end
      do_access(0, 1'b0, 24'h010004, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (dout !== 8'hFF) begin n_bad++; $display("FAIL oor_rd_data: got %h want ff", dout); end
      n_cmp++; if (flt !== 1'b1) begin n_bad++; $display("FAIL oor_rd_fault: got %b want 1", flt); end
   endtask

   // T6: inputs changed while busy must not affect the access in flight.
   task automatic test_busy_ignore();
      int lat; logic [7:0] dout; logic flt, ba, br, ra;
      do_access(0, 1'b1, 24'h000021, 8'h66, lat, dout, flt, ba, br, ra);
      do_access(0, 1'b0, 24'h000010, 8'h00, lat, dout, flt, ba, br, ra);
      @(negedge clk);
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 24'h000020; din_v[0] = 8'hAA;
      @(posedge clk); #1;
      we_v[0] = 1'b0; addr_v[0] = 24'h000021; din_v[0] = 8'h55;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_v[0] = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (ready_v[0] !== 1'b1) begin n_bad++; $display("FAIL busy_ign_ready: got %b want 1", ready_v[0]); end
      n_cmp++; if (dout_v[0] !== 8'h5A) begin n_bad++; $display("FAIL busy_ign_still_write: got %h want 5a", dout_v[0]); end
      do_access(0, 1'b0, 24'h000020, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (dout !== 8'hAA) begin n_bad++; $display("FAIL busy_ign_latched_data: got %h want aa", dout); end
      do_access(0, 1'b0, 24'h000021, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (dout !== 8'h66) begin n_bad++; $display("FAIL busy_ign_other_addr: got %h want 66", dout); end
   endtask

   // T2: zero wait states with req held high -> one completion every 2 cycles.
   task automatic test_back_to_back();
      int lat; logic [7:0] dout; logic flt, ba, br, ra;
      do_access(1, 1'b1, 24'h000000, 8'h77, lat, dout, flt, ba, br, ra);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ws0_latency: got %0d want 1", lat); end
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 24'h000000;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (ready_v[1] !== k[0] || busy_v[1] !== !k[0]) begin
            n_bad++;
            $display("FAIL b2b_cycle%0d: got rdy=%b busy=%b want rdy=%b busy=%b",
                     k, ready_v[1], busy_v[1], k[0], !k[0]);
         end
         if (k[0]) begin
            n_cmp++;
            if (dout_v[1] !== 8'h77 || fault_v[1] !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b_data%0d: got %h/%b want 77/0", k, dout_v[1], fault_v[1]);
            end
         end
      end
      req_v[1] = 1'b0;
      @(posedge clk); #1;
   endtask

   // T4: mirrored aliasing on u1.
   task automatic test_mirror();
      int lat; logic [7:0] dout; logic flt, ba, br, ra;
      do_access(1, 1'b1, 24'h7F0008, 8'h22, lat, dout, flt, ba, br, ra);
      n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL mirror_wr_fault: got %b want 0", flt); end
      do_access(1, 1'b0, 24'h000008, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (dout !== 8'h22) begin n_bad++; $display("FAIL mirror_rd_data: got %h want 22", dout); end
      n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL mirror_rd_fault: got %b want 0", flt); end
   endtask

   // T5: reset during WAIT aborts a write on u2 (3 wait states).
   task automatic test_reset_abort();
      int lat; logic [7:0] dout; logic flt, ba, br, ra;
      do_access(2, 1'b1, 24'h000005, 8'h44, lat, dout, flt, ba, br, ra);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_latency: got %0d want 4", lat); end
      do_access(2, 1'b0, 24'h000005, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (dout !== 8'h44) begin n_bad++; $display("FAIL ws3_rd_data: got %h want 44", dout); end
      @(negedge clk);
      req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 24'h000005; din_v[2] = 8'h33;
      @(posedge clk); #1;
      req_v[2] = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (busy_v[2] !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy_v[2]); end
      rst_v[2] = 1'b0;
      #1;
      n_cmp++;
      if ({dout_v[2], ready_v[2], fault_v[2], busy_v[2]} !== 11'h0) begin
         n_bad++;
         $display("FAIL abort_async_outputs: got dout=%h rdy=%b flt=%b busy=%b want all 0",
                  dout_v[2], ready_v[2], fault_v[2], busy_v[2]);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_v[2] = 1'b1;
      do_access(2, 1'b0, 24'h000005, 8'h00, lat, dout, flt, ba, br, ra);
      n_cmp++; if (dout !== 8'h44) begin n_bad++; $display("FAIL abort_write_dropped: got %h want 44", dout); end
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL abort_then_latency: got %0d want 4", lat); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_range_fault();
      test_busy_ignore();
      test_back_to_back();
      test_mirror();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
